// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 3x4 matrix keypad model driving row lines from a timed key command
// Optional contact bounce: define KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator #(
    parameter int PRESS_CYC  = 1_000_000,
    parameter int GAP_CYC    = 1_000_000,
    parameter int BOUNCE_CYC = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] col,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_key,
    output logic       cmd_ready,
    output logic [3:0] row,
    output logic       busy,
    output logic       done,
    output logic       err
);

    if (PRESS_CYC < 1 || PRESS_CYC > 24'hFFFFFF || GAP_CYC < 1 || GAP_CYC > 24'hFFFFFF ||
        BOUNCE_CYC < 1 || BOUNCE_CYC > 24'hFFFFFF) begin : g_param_check
        $error("keypad_emulator: phase lengths must be 1 .. 2^24-1");
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    typedef enum logic [2:0] {S_IDLE, S_BOUNCE_ON, S_HOLD, S_BOUNCE_OFF, S_GAP} state_t;
    localparam logic [23:0] BOUNCE_LOAD = 24'(BOUNCE_CYC - 1);
`else
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;
`endif

    localparam logic [23:0] PRESS_LOAD = 24'(PRESS_CYC - 1);
    localparam logic [23:0] GAP_LOAD   = 24'(GAP_CYC - 1);

    state_t      state;
    logic [23:0] cnt;
    logic [1:0]  key_row;
    logic [1:0]  key_col;
    logic        done_q;
    logic        err_q;
    logic        contact;
    logic        col_sel;
    logic        cnt_zero;
    logic        key_ok;
    logic [1:0]  dec_row;
    logic [1:0]  dec_col;

    assign cnt_zero = (cnt == 24'd0);
    assign key_ok   = (cmd_key < 4'd12);
    assign dec_row  = 2'(cmd_key / 4'd3);
    assign dec_col  = 2'(cmd_key % 4'd3);

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [7:0] lfsr;

    // x^8+x^6+x^5+x^4+1; advances only while chattering so patterns repeat after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else if (state == S_BOUNCE_ON || state == S_BOUNCE_OFF) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 24'd0;
            key_row <= 2'd0;
            key_col <= 2'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (key_ok) begin
                            key_row <= dec_row;
                            key_col <= dec_col;
`ifdef KEYPAD_EMU_BOUNCE_EN
                            state   <= S_BOUNCE_ON;
                            cnt     <= BOUNCE_LOAD;
`else
                            state   <= S_HOLD;
                            cnt     <= PRESS_LOAD;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                S_BOUNCE_ON: begin
                    if (cnt_zero) begin
                        state <= S_HOLD;
                        cnt   <= PRESS_LOAD;
                    end else begin
                        cnt <= cnt - 24'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt_zero) begin
                        state <= S_BOUNCE_OFF;
                        cnt   <= BOUNCE_LOAD;
                    end else begin
                        cnt <= cnt - 24'd1;
                    end
                end
                S_BOUNCE_OFF: begin
                    if (cnt_zero) begin
                        state <= S_GAP;
                        cnt   <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - 24'd1;
                    end
                end
`else
                S_HOLD: begin
                    if (cnt_zero) begin
                        state <= S_GAP;
                        cnt   <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - 24'd1;
                    end
                end
`endif
                S_GAP: begin
                    if (cnt_zero) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 24'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 24'd0;
                end
            endcase
        end
    end

    always_comb begin
        contact = 1'b0;
        case (state)
            S_HOLD:       contact = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            S_BOUNCE_ON:  contact = lfsr[0];
            S_BOUNCE_OFF: contact = lfsr[0];
`endif
            default:      contact = 1'b0;
        endcase
    end

    // Live column path: the switch connects row to column with no clocking
    always_comb begin
        col_sel = col[2];
        case (key_col)
            2'd0:    col_sel = col[0];
            2'd1:    col_sel = col[1];
            default: col_sel = col[2];
        endcase
    end

    assign row       = (contact & col_sel) ? (4'b0001 << key_row) : 4'b0000;
    assign cmd_ready = (state == S_IDLE);
    assign busy      = !cmd_ready;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - directed self-checking bench for keypad_emulator (PRESS=8, GAP=4, BOUNCE=4)
module tb_keypad_emulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] col;
    logic       cmd_valid;
    logic [3:0] cmd_key;
    logic       cmd_ready;
    logic [3:0] row;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    keypad_emulator #(
        .PRESS_CYC (8),
        .GAP_CYC   (4),
        .BOUNCE_CYC(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col      (col),
        .cmd_valid(cmd_valid),
        .cmd_key  (cmd_key),
        .cmd_ready(cmd_ready),
        .row      (row),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present a key for one edge; returns in cycle 1 after acceptance
    task automatic press(input logic [3:0] key);
        cmd_key   = key;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        #1;
    endtask

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [7:0] m;
`endif

    initial begin
        rst_n     = 1'b0;
        col       = 3'b000;
        cmd_valid = 1'b0;
        cmd_key   = 4'd0;
        #2;
        do_reset();
        chk("rst_row", 32'(row), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

`ifdef KEYPAD_EMU_BOUNCE_EN
        // Key 7: row 2, column 1
        col = 3'b010;
        m   = 8'hA5;
        press(4'd7);
        for (int c = 1; c <= 21; c++) begin
            if (c <= 4 || (c >= 13 && c <= 16)) begin
                chk("b7_row_bounce", 32'(row), m[0] ? 32'h4 : 32'h0);
                m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
            end else if (c <= 12) begin
                chk("b7_row_hold", 32'(row), 32'h4);
            end else begin
                chk("b7_row_off", 32'(row), 32'h0);
            end
            chk("b7_done", 32'(done), (c == 21) ? 32'h1 : 32'h0);
            chk("b7_busy", 32'(busy), (c <= 20) ? 32'h1 : 32'h0);
            if (c < 21) step();
        end

        // Asynchronous reset in the middle of the clean hold
        press(4'd7);
        repeat (8) step();
        chk("b7_mid_row", 32'(row), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_row", 32'(row), 32'h0);
        chk("arst_ready", 32'(cmd_ready), 32'h1);
        chk("arst_busy", 32'(busy), 32'h0);
        step();
        rst_n = 1'b1;
`else
        // Key 4 (row 1, column 1) with its column driven
        col = 3'b010;
        press(4'd4);
        for (int c = 1; c <= 13; c++) begin
            chk("k4_row", 32'(row), (c <= 8) ? 32'h2 : 32'h0);
            chk("k4_done", 32'(done), (c == 13) ? 32'h1 : 32'h0);
            chk("k4_busy", 32'(busy), (c <= 12) ? 32'h1 : 32'h0);
            if (c < 13) step();
        end

        // Key 4 with a different column driven: never connects
        col = 3'b001;
        press(4'd4);
        for (int c = 1; c <= 13; c++) begin
            chk("k4c0_row", 32'(row), 32'h0);
            chk("k4c0_done", 32'(done), (c == 13) ? 32'h1 : 32'h0);
            if (c < 13) step();
        end

        // Key 11 (row 3, column 2): column switches mid-hold
        col = 3'b001;
        press(4'd11);
        for (int c = 1; c <= 3; c++) begin
            chk("k11_row_pre", 32'(row), 32'h0);
            step();
        end
        col = 3'b100;
        #1;
        for (int c = 4; c <= 13; c++) begin
            chk("k11_row", 32'(row), (c <= 8) ? 32'h8 : 32'h0);
            chk("k11_done", 32'(done), (c == 13) ? 32'h1 : 32'h0);
            if (c < 13) step();
        end

        // Key 0 with every column driven
        col = 3'b111;
        press(4'd0);
        for (int c = 1; c <= 13; c++) begin
            chk("k0_row", 32'(row), (c <= 8) ? 32'h1 : 32'h0);
            chk("k0_done", 32'(done), (c == 13) ? 32'h1 : 32'h0);
            if (c < 13) step();
        end

        // Invalid key 12
        press(4'd12);
        chk("inv_err1", 32'(err), 32'h1);
        chk("inv_ready1", 32'(cmd_ready), 32'h1);
        chk("inv_row1", 32'(row), 32'h0);
        for (int c = 2; c <= 14; c++) begin
            step();
            chk("inv_err", 32'(err), 32'h0);
            chk("inv_done", 32'(done), 32'h0);
            chk("inv_ready", 32'(cmd_ready), 32'h1);
            chk("inv_row", 32'(row), 32'h0);
        end

        // Back-to-back: valid held, second key waits for the done cycle
        col       = 3'b010;
        cmd_key   = 4'd4;
        cmd_valid = 1'b1;
        step();
        cmd_key = 4'd1;
        for (int c = 1; c <= 13; c++) begin
            chk("bb_row_a", 32'(row), (c <= 8) ? 32'h2 : 32'h0);
            chk("bb_done_a", 32'(done), (c == 13) ? 32'h1 : 32'h0);
            chk("bb_ready_a", 32'(cmd_ready), (c == 13) ? 32'h1 : 32'h0);
            step();
        end
        cmd_valid = 1'b0;
        chk("bb_busy_b", 32'(busy), 32'h1);
        for (int c = 1; c <= 13; c++) begin
            chk("bb_row_b", 32'(row), (c <= 8) ? 32'h1 : 32'h0);
            chk("bb_done_b", 32'(done), (c == 13) ? 32'h1 : 32'h0);
            if (c < 13) step();
        end

        // Mid-press asynchronous reset
        press(4'd4);
        repeat (3) step();
        chk("mid_row", 32'(row), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_row", 32'(row), 32'h0);
        chk("arst_ready", 32'(cmd_ready), 32'h1);
        chk("arst_busy", 32'(busy), 32'h0);
        step();
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable 3x4 matrix-keypad model that answers the column scan of the keypad scanner by driving the row lines, as a physical keypad would. It sits in place of the real keypad, on the scanner's `row`/`col` pins, for board self-test and automated code entry. It accepts one key command at a time and produces a timed press (optional contact bounce), hold, release and gap sequence.

## Interface
Parameters:
- `PRESS_CYC`, default 1_000_000: clean-contact hold length in cycles (1 .. 2^24-1).
- `GAP_CYC`, default 1_000_000: released time after each key, in cycles (1 .. 2^24-1).
- `BOUNCE_CYC`, default 50_000: length of each bounce phase, in cycles (1 .. 2^24-1). Used only with the bounce macro.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `col` in 3: scanner column drive, active-high; bit c selects column c.
- `cmd_valid` in 1: key command present.
- `cmd_key` in 4: key index 0..11. Row = key/3, column = key%3.
- `cmd_ready` out 1: high only in IDLE.
- `row` out 4: row lines, active-high; `row[r]` = contact & (r == key row) & `col[key column]`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a key sequence completes.
- `err` out 1: one-cycle pulse when a command with `cmd_key` ≥ 12 is accepted.

## Operation
- The FSM has five states: IDLE, BOUNCE_ON, HOLD, BOUNCE_OFF, GAP.
- A command is accepted on the edge where `cmd_valid & cmd_ready` is high. On acceptance:
  - Key index and row/column are latched.
  - The 24-bit down-counter is loaded with the phase length minus 1.
  - The FSM enters BOUNCE_ON. Without the bounce macro it enters HOLD.
- Each phase lasts exactly its length in cycles. The FSM advances when the counter is 0.
  - Phase order: BOUNCE_ON → HOLD → BOUNCE_OFF → GAP → IDLE.
  - Without the bounce macro: HOLD → GAP → IDLE.
- Contact value per state:
  - HOLD: 1.
  - GAP and IDLE: 0.
  - BOUNCE_ON and BOUNCE_OFF: `lfsr[0]`.
- `row` is combinational from the registered contact/key state and the live `col`. There is zero latency from `col` to `row`, as with physical switches. If several `col` bits are high, the row still follows the selected column's bit.
- Invalid key (≥ 12):
  - The command is accepted and `err` pulses on the next cycle.
  - The FSM stays in IDLE: no press, no `done`.
- `cmd_valid` while busy is ignored. The command is not queued.
- `done` and `cmd_ready` go high together in the first IDLE cycle. A new command may be accepted in that same cycle.
- Reset, at any time including mid-press:
  - State IDLE, counter 0, LFSR = 8'hA5.
  - `row`=0, `cmd_ready`=1, `busy`=0, `done`=0, `err`=0, all immediately.

## Timing
- Number cycles from 1, starting after the acceptance edge.
- Without bounce:
  - HOLD occupies cycles 1..PRESS_CYC.
  - GAP occupies the next GAP_CYC cycles.
  - `done` is high in cycle PRESS_CYC+GAP_CYC+1.
- With bounce: the sequence is BOUNCE_CYC + PRESS_CYC + BOUNCE_CYC + GAP_CYC cycles, then `done`.
- The LFSR is 8 bits, polynomial x^8+x^6+x^5+x^4+1. It shifts every cycle in the bounce states only and holds otherwise, so bounce patterns are deterministic after reset.
- `err` is high one cycle, in cycle 1 after acceptance. `cmd_ready` stays high throughout.
- `busy` = !`cmd_ready`.

## Configuration
- `KEYPAD_EMU_BOUNCE_EN` defined:
  - BOUNCE_ON and BOUNCE_OFF states, the LFSR and `BOUNCE_CYC` are compiled in.
  - The contact chatters at press and release.
- Not defined:
  - The bounce states, LFSR and their logic are absent.
  - The contact makes and breaks cleanly.
  - `BOUNCE_CYC` is ignored.

## Test plan
Benches use PRESS_CYC=8, GAP_CYC=4, BOUNCE_CYC=4.
- Reset check: assert `rst_n`=0 for 3 cycles, then release → `row`=0, `cmd_ready`=1, `busy`=0, `done`=0, `err`=0.
- Key 4, no bounce, `col`=3'b010 → `row`=4'b0010 in cycles 1..8. `row`=0 in cycles 9..12. `done` pulses in cycle 13. With `col`=3'b001 instead, `row`=0 throughout.
- Key 11 with `col` switching 3'b001 → 3'b100 mid-HOLD → `row` goes 0 → 4'b1000 in the same cycle as the `col` change. Key 0 with `col`=3'b111 → `row`=4'b0001.
- Invalid key: `cmd_key`=12 accepted → `err`=1 in cycle 1 only. `cmd_ready` stays 1, `row` stays 0, no `done`.
- Busy and back-to-back: `cmd_valid` held high during a press → second key ignored until the `done` cycle, accepted there, second press starts the next cycle.
- Bounce build (`KEYPAD_EMU_BOUNCE_EN`):
  - Key 7 → `row` bit 2 follows `lfsr[0]` from seed 8'hA5 in cycles 1..4, is steady 1 in cycles 5..12, follows the LFSR in 13..16, is 0 in 17..20; `done` pulses in cycle 21.
  - `rst_n` pulled low in cycle 9 → `row`=0 asynchronously and `cmd_ready`=1.
